// File: rtl/de0_pll_supervisor_pkg.sv
// de0_pll_supervisor_pkg
//   Shared definitions for the DE0 PLL supervisor: FSM state encoding,
//   default parameter values and a small saturating-increment helper.
package de0_pll_supervisor_pkg;

  typedef enum logic [2:0] {
    S_PLLRST   = 3'd0,
    S_WAITLOCK = 3'd1,
    S_STABLE   = 3'd2,
    S_RUN      = 3'd3,
    S_FAIL     = 3'd4
  } state_e;

  localparam int DEF_PLL_RST_CYCLES = 16;
  localparam int DEF_LOCK_TIMEOUT   = 50000;  // 1 ms @ 50 MHz
  localparam int DEF_LOCK_STABLE    = 1024;
  localparam int DEF_MAX_RETRY      = 7;
  localparam int DEF_CNT_W          = 16;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/de0_pll_supervisor_sync2.sv
// de0_sync2
//   Generic 2-FF synchroniser, asynchronous active-high reset to 0.
//   Ports:
//     clk  in         destination clock
//     rst  in         async reset, active-high
//     d    in  WIDTH  asynchronous input(s)
//     q    out WIDTH  synchronised output, 2 cycles of latency
module de0_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/de0_pll_supervisor.sv
// de0_pll_supervisor
//   Reset/lock supervisor around the DE0 PLL, clocked by the raw board clock.
//   Pulses the PLL reset, waits for a lock that stays up for LOCK_STABLE
//   cycles before releasing sys_rst, retries on lock timeout and gives up
//   (sticky fail) after MAX_RETRY consecutive timeouts.
//   Ports:
//     clkin       in   raw 50 MHz board clock (also PLL reference)
//     rst         in   async reset, active-high
//     locked      in   PLL locked, asynchronous to clkin
//     pll_rst     out  PLL reset, active-high
//     sys_rst     out  design reset, active-high, low only in RUN
//     ready       out  inverse of sys_rst, registered
//     fail        out  sticky: PLL never locked within MAX_RETRY attempts
//     relock_cnt  out  [7:0] lock losses seen in RUN, saturating at 255
module de0_pll_supervisor
  import de0_pll_supervisor_pkg::*;
#(
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int LOCK_STABLE    = DEF_LOCK_STABLE,
  parameter int MAX_RETRY      = DEF_MAX_RETRY,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [7:0] relock_cnt
);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [7:0]       RETRY_MAX   = 8'(MAX_RETRY);

  logic lock_s;

  de0_sync2 #(.WIDTH(1)) u_lock_sync (
    .clk (clkin),
    .rst (rst),
    .d   (locked),
    .q   (lock_s)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       retry_q, retry_d;
  logic [7:0]       relock_q, relock_d;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_rst_q, sys_rst_d;
  logic             ready_q, ready_d;
  logic             fail_q, fail_d;

  // State register and registered outputs
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_q   <= S_PLLRST;
      cnt_q     <= '0;
      retry_q   <= '0;
      relock_q  <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      relock_q  <= relock_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
    end
  end

  // Next state. Every transition clears cnt, so it never wraps.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    retry_d  = retry_q;
    relock_d = relock_q;
    case (state_q)
      S_PLLRST: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_WAITLOCK;
          cnt_d   = '0;
        end
      end
      S_WAITLOCK: begin
        // A lock arriving on the timeout cycle wins over the retry.
        if (lock_s) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          retry_d = retry_q + 8'd1;
          state_d = (retry_d == RETRY_MAX) ? S_FAIL : S_PLLRST;
          cnt_d   = '0;
        end
      end
      S_STABLE: begin
        // A lock drop beats reaching the stable count on the same cycle.
        if (!lock_s) begin
          state_d = S_WAITLOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = S_RUN;
          retry_d = '0;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        cnt_d = '0;
        if (!lock_s) begin
          relock_d = sat_inc8(relock_q);
          state_d  = S_PLLRST;
        end
      end
      S_FAIL: begin
        cnt_d = '0;
      end
      default: begin
        state_d = S_PLLRST;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decoded from the next state so they change on the same edge.
  always_comb begin
    pll_rst_d = (state_d == S_PLLRST);
    sys_rst_d = (state_d != S_RUN);
    ready_d   = (state_d == S_RUN);
    fail_d    = (state_d == S_FAIL);
  end

  assign pll_rst    = pll_rst_q;
  assign sys_rst    = sys_rst_q;
  assign ready      = ready_q;
  assign fail       = fail_q;
  assign relock_cnt = relock_q;

endmodule

// File: tb/tb_de0_pll_supervisor.sv
module tb_de0_pll_supervisor;

  localparam int P_RST  = 4;
  localparam int P_TO   = 20;
  localparam int P_STB  = 8;
  localparam int P_RETR = 3;

  logic       clkin = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic       pll_rst, sys_rst, ready, fail;
  logic [7:0] relock_cnt;

  int checks = 0;
  int errors = 0;

  de0_pll_supervisor #(
    .PLL_RST_CYCLES(P_RST), .LOCK_TIMEOUT(P_TO), .LOCK_STABLE(P_STB),
    .MAX_RETRY(P_RETR), .CNT_W(16)
  ) dut (
    .clkin(clkin), .rst(rst), .locked(locked), .pll_rst(pll_rst),
    .sys_rst(sys_rst), .ready(ready), .fail(fail), .relock_cnt(relock_cnt)
  );

  always #5 clkin = ~clkin;

  // ---------------- behavioural model ----------------
  // Phase timing is derived from the edge number at which the phase was
  // entered; the synchroniser is a 2-deep history of sampled 'locked'.
  localparam int PH_PLLRST = 0, PH_WAIT = 1, PH_STABLE = 2, PH_RUN = 3, PH_FAIL = 4;
  int m_ph, m_entry, m_edge, m_retries, m_relocks;
  bit m_l1, m_l2;

  always @(posedge clkin or posedge rst) begin
    if (rst) begin
      m_ph = PH_PLLRST; m_entry = 0; m_edge = 0;
      m_retries = 0; m_relocks = 0; m_l1 = 0; m_l2 = 0;
    end else begin
      bit ls;
      int el;
      int nxt;
      m_edge++;
      ls = m_l2; m_l2 = m_l1; m_l1 = locked;
      el = m_edge - m_entry - 1;
      nxt = m_ph;
      if (m_ph == PH_PLLRST) begin
        if (el == P_RST - 1) nxt = PH_WAIT;
      end else if (m_ph == PH_WAIT) begin
        if (ls) nxt = PH_STABLE;
        else if (el == P_TO - 1) begin
          m_retries++;
          nxt = (m_retries == P_RETR) ? PH_FAIL : PH_PLLRST;
        end
      end else if (m_ph == PH_STABLE) begin
        if (!ls) nxt = PH_WAIT;
        else if (el == P_STB - 1) begin m_retries = 0; nxt = PH_RUN; end
      end else if (m_ph == PH_RUN) begin
        if (!ls) begin
          m_relocks = (m_relocks < 255) ? m_relocks + 1 : 255;
          nxt = PH_PLLRST;
        end
      end
      if (nxt != m_ph) begin m_ph = nxt; m_entry = m_edge; end
    end
  end

  // Cycle-by-cycle compare on the falling edge
  always @(negedge clkin) begin
    logic [11:0] exp_v, act_v;
    exp_v = {m_ph == PH_PLLRST, m_ph != PH_RUN, m_ph == PH_RUN, m_ph == PH_FAIL, 8'(m_relocks)};
    act_v = {pll_rst, sys_rst, ready, fail, relock_cnt};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL model_cmp t=%0t got pll/sys/rdy/fail/relock=%b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d",
               $time, act_v[11], act_v[10], act_v[9], act_v[8], act_v[7:0],
               exp_v[11], exp_v[10], exp_v[9], exp_v[8], exp_v[7:0]);
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clkin);
    #1;
  endtask

  // Leaves the bench between edges; the next rising edge is edge 1.
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clkin);
    #2 rst = 1'b0;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_pll_rst"}, 32'(pll_rst), 1);
    chk({nm, "_sys_rst"}, 32'(sys_rst), 1);
    chk({nm, "_ready"},   32'(ready), 0);
    chk({nm, "_fail"},    32'(fail), 0);
    chk({nm, "_relock"},  32'(relock_cnt), 0);
  endtask

  task automatic wait_ready(input string nm);
    int budget;
    budget = 200;
    while (!ready && budget > 0) begin step(1); budget--; end
    chk({nm, "_ready_timeout"}, 32'(ready), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clkin);
    #1 chk_reset_vals("reset");
    #1 rst = 1'b0;  // next rising edge is edge 1

    // Never locks: three pulses, fail at edge 72
    step(3);  chk("pll_rst_e3", 32'(pll_rst), 1);
    step(1);  chk("pll_rst_e4", 32'(pll_rst), 0);
    step(20); chk("pll_rst_e24", 32'(pll_rst), 1);
    step(4);  chk("pll_rst_e28", 32'(pll_rst), 0);
    step(20); chk("pll_rst_e48", 32'(pll_rst), 1);
    step(23); chk("fail_e71", 32'(fail), 0);
    step(1);  chk("fail_e72", 32'(fail), 1);
              chk("fail_pll_rst", 32'(pll_rst), 0);
    step(10); chk("fail_sticky", 32'(fail), 1);
              chk("fail_sys_rst", 32'(sys_rst), 1);
    #2 rst = 1'b1;
    #1 chk_reset_vals("async_fail");

    // Lock present from edge 1: STABLE at edge 5, RUN at edge 13
    locked = 1'b1;
    do_reset();
    step(12); chk("ready_e12", 32'(ready), 0);
    step(1);  chk("ready_e13", 32'(ready), 1);
              chk("sys_rst_e13", 32'(sys_rst), 0);

    // Glitch in STABLE at cnt=5: full stable window restarts, RUN at edge 20
    do_reset();
    step(8); locked = 1'b0;
    step(1); locked = 1'b1;
    step(2);  chk("glitch_sys_rst_e11", 32'(sys_rst), 1);
    step(8);  chk("glitch_ready_e19", 32'(ready), 0);
    step(1);  chk("glitch_ready_e20", 32'(ready), 1);

    // Lock loss in RUN, 260 times: relock_cnt saturates
    step(2);
    locked = 1'b0; step(1); locked = 1'b1;
    step(1); chk("drop_sys_rst_e1", 32'(sys_rst), 0);
    step(1); chk("drop_sys_rst_e2", 32'(sys_rst), 1);
             chk("drop_relock", 32'(relock_cnt), 1);
             chk("drop_pll_rst", 32'(pll_rst), 1);
    wait_ready("relock0");
    for (int i = 1; i < 260; i++) begin
      locked = 1'b0; step(1); locked = 1'b1;
      step(2);
      wait_ready("relock_loop");
    end
    chk("relock_sat", 32'(relock_cnt), 255);
    step(1);
    #1 rst = 1'b1;
    #1 chk_reset_vals("async_run");

    // Randomised episodes with run-length locked patterns and rare async resets
    for (int ep = 0; ep < 40; ep++) begin
      locked = 1'($urandom_range(0, 1));
      do_reset();
      for (int c = 0; c < 300; ) begin
        int len;
        if ($urandom_range(0, 3) != 0) begin locked = 1'b1; len = $urandom_range(1, 40); end
        else begin locked = 1'b0; len = $urandom_range(1, 25); end
        step(len);
        c += len;
        if ($urandom_range(0, 99) == 0) begin
          #2 rst = 1'b1;
          #4 rst = 1'b0;
        end
      end
    end

    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
